// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states, timeout default.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == SZ_RSVD) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_steer.sv
// Byte-lane steering: store byte enables / replicated write data, load lane selection.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_lane_steer
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [7:0]  o_a8,
  output logic [15:0] o_a16
);

  // Store side: byte enables shifted to the addressed lane, data replicated over all lanes.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load side: pick the byte lane by addr[1:0] and the halfword lane by addr[1].
  always_comb begin
    o_a8 = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    o_a8 = i_rdata[7:0];
      2'd1:    o_a8 = i_rdata[15:8];
      2'd2:    o_a8 = i_rdata[23:16];
      default: o_a8 = i_rdata[31:24];
    endcase
    o_a16 = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the pipeline and a ready-handshaked memory.
// Latency: 1 (accept) + N (ACCESS until mem_ready) + 1 (DONE) cycles; timeout after TIMEOUT waits.
// Backpressure: req_stall high from the accept cycle until DONE/ERR. Macro MEM_ACCESS_MISALIGN_TRAP_EN
//   makes misaligned half/word requests fault without a memory access; default aligns them down.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [7:0]        A8,
  output logic [15:0]       A16,
  output logic [DATA_W-1:0] A32,
  output logic [1:0]        byte_sel,
  output logic              LoadExtOp,
  output logic              ld_valid,
  output logic              fault
);

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_load;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_a8;
  logic [15:0]       r_a16;
  logic [DATA_W-1:0] r_a32;
  logic [1:0]        r_byte_sel;

  logic [1:0]        w_size_n;
  logic [DATA_W-1:0] w_addr_eff;
  logic              w_trap;
  logic              w_access;
  logic [3:0]        w_cnt_inc;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [7:0]        w_a8;
  logic [15:0]       w_a16;

  assign w_size_n  = norm_size(req_size);
  assign w_access  = (r_state == ST_ACCESS);
  assign w_cnt_inc = r_cnt + 4'd1;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  // Misaligned half/word requests are refused and reported as a fault.
  assign w_trap     = ((w_size_n == SZ_HALF) && req_addr[0]) ||
                      ((w_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_addr_eff = req_addr;
`else
  // Misaligned half/word requests are silently aligned down and proceed.
  assign w_trap = 1'b0;
  always_comb begin
    w_addr_eff = req_addr;
    if (w_size_n == SZ_HALF)      w_addr_eff[0]   = 1'b0;
    else if (w_size_n == SZ_WORD) w_addr_eff[1:0] = 2'b00;
  end
`endif

  mem_lane_steer u_steer (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_a8      (w_a8),
    .o_a16     (w_a16)
  );

  // Control FSM and ACCESS wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cnt   <= 4'd0;
            r_state <= w_trap ? ST_ERR : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == LP_TIMEOUT) r_state <= ST_ERR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Request capture on accept and load-result capture on the completing ACCESS cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load     <= 1'b0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_a8       <= '0;
      r_a16      <= '0;
      r_a32      <= '0;
      r_byte_sel <= 2'b00;
    end else begin
      if ((r_state == ST_IDLE) && req_valid) begin
        r_load   <= req_load;
        r_size   <= w_size_n;
        r_signed <= req_signed;
        r_addr   <= w_addr_eff;
        r_wdata  <= req_wdata;
      end
      if (w_access && mem_ready && r_load) begin
        r_a8       <= w_a8;
        r_a16      <= w_a16;
        r_a32      <= mem_rdata;
        r_byte_sel <= r_size;
      end
    end
  end

  // Stall: combinational in the accept cycle, held through ACCESS, released in DONE/ERR.
  always_comb begin
    req_stall = 1'b0;
    case (r_state)
      ST_IDLE:   req_stall = reset_n & req_valid;
      ST_ACCESS: req_stall = 1'b1;
      default:   req_stall = 1'b0;
    endcase
  end

  // Memory-side outputs are only driven while a transfer is in flight.
  assign mem_req   = w_access;
  assign mem_we    = w_access & ~r_load;
  assign mem_addr  = w_access ? {r_addr[DATA_W-1:2], 2'b00} : '0;
  assign mem_be    = w_access ? w_be : 4'b0000;
  assign mem_wdata = w_access ? w_wdata_rep : '0;

  assign A8        = r_a8;
  assign A16       = r_a16;
  assign A32       = r_a32;
  assign byte_sel  = r_byte_sel;
  assign LoadExtOp = r_signed;
  assign ld_valid  = (r_state == ST_DONE) & r_load;
  assign fault     = (r_state == ST_ERR);

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, data/address width; TIMEOUT, 15, max cycles waiting for mem_ready (4-bit counter).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock; one clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline request.
- req_load  in  1  1=load, 0=store.
- req_size  in  2  00 byte, 01 half, 11 word; 10 reserved.
- req_signed  in  1  load sign-extend request.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_stall  out  1  pipeline must hold request.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data.
- mem_ready  in  1  memory accept/complete.
- A8  out  8  selected load byte.
- A16  out  16  selected load halfword.
- A32  out  32  full load word.
- byte_sel  out  2  size code for extend stage.
- LoadExtOp  out  1  registered req_signed.
- ld_valid  out  1  one-cycle load-data strobe.
- fault  out  1  one-cycle misalign/timeout strobe.

Function
REQ-003 FSM SHALL have states IDLE, ACCESS, DONE, ERR.
REQ-004 IDLE: on req_valid, SHALL latch load, size, signed, addr, wdata and go to ACCESS next cycle; req_stall SHALL assert combinationally in that cycle.
REQ-005 ACCESS: SHALL hold mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata until mem_ready=1, then go to DONE.
REQ-006 mem_addr SHALL be {addr[31:2],2'b00}; mem_be SHALL be 0001<<addr[1:0] for bytes, 0011<<addr[1:0] for halves, 1111 for words.
REQ-007 mem_wdata SHALL be byte replicated ×4, half replicated ×2, or word as-is.
REQ-008 On the mem_ready cycle of a load, SHALL register A32=mem_rdata, A8=byte lane addr[1:0], A16=half lane addr[1], byte_sel=size.
REQ-009 DONE: SHALL pulse ld_valid (loads only) for one cycle, deassert req_stall, return to IDLE; end-to-end latency SHALL be 1+N+1 cycles for N ACCESS cycles (minimum 3).
REQ-010 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without mem_ready; on reaching TIMEOUT, SHALL drop mem_req and go to ERR.
REQ-011 ERR: SHALL pulse fault for one cycle, deassert req_stall, return to IDLE; A8/A16/A32 SHALL hold previous values.
REQ-012 Reserved size 10 SHALL be treated as word.
REQ-013 req_valid in non-IDLE states SHALL be ignored; req_stall stays high until DONE/ERR.
REQ-014 mem_ready in IDLE/DONE/ERR SHALL be ignored.

Reset
REQ-015 reset_n low SHALL asynchronously force IDLE, counter 0, and all outputs 0, including mid-ACCESS (mem_req drops immediately).
REQ-016 Deassertion SHALL take effect on the next rising clk edge.

Configuration
REQ-017 With MEM_ACCESS_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->ERR, with no mem_req.
REQ-018 Without the macro: misaligned requests SHALL have low address bits forced to zero (half: addr[0]; word: addr[1:0]) and proceed normally; fault SHALL only arise from timeout.

Structure
REQ-019 A shared package SHALL hold size codes (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=11), the FSM state enum, and TIMEOUT default.
REQ-020 One sub-module, mem_lane_steer, SHALL implement combinational be/wdata generation and load lane selection.

Verification
REQ-021 Byte load at addr 0x0000_1003, mem_rdata 0xA1B2C3D4, ready in first ACCESS -> mem_be=1000, A8=0xA1, byte_sel=00, ld_valid at cycle 3.
REQ-022 Half store of 0x0000_BEEF at 0x0000_2002 -> mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x0000_2000, no ld_valid.
REQ-023 Word load, mem_ready withheld 16 cycles -> mem_req drops after 15 ACCESS cycles, fault pulses once, req_stall falls.
REQ-024 Word load at 0x0000_0006 -> with macro: fault, no mem_req; without macro: mem_addr=0x0000_0004, mem_be=1111.
REQ-025 reset_n low during ACCESS with mem_req=1 -> mem_req=0 and req_stall=0 with no clock edge; subsequent request completes normally.
REQ-026 Back-to-back loads with req_valid held -> second request accepted only in the cycle after the first ld_valid.
